// File: rtl/hamming_arb.sv
// hamming_arb
// Two-requester round-robin front end for a single iterative Hamming-distance
// datapath. A granted operand pair is reduced BPC bits per cycle. The result
// is then offered on a valid/ready port, tagged with the owning requester.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/_ready         request handshake per requester
//   req{0,1}_val1/_val2           operand pair, sampled only on accept
//   res_valid/res_ready           result handshake
//   res_id, res_dist              owner of the result and its distance
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grants one of the valid requesters
// CALC  | accumulating popcount of the captured xor, BPC bits per cycle
// DONE  | result presented; held until the consumer takes it
module hamming_arb #(
    parameter int WIDTH = 16,
    parameter int BPC   = 4,
    parameter int DW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_val1,
    input  logic [WIDTH-1:0] req0_val2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_val1,
    input  logic [WIDTH-1:0] req1_val2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [DW-1:0]    res_dist
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic [DW-1:0]    res_dist_q, res_dist_d;

    logic             grant;
    logic             accept;
    logic [DW-1:0]    acc_sum;

    function automatic logic [DW-1:0] popcnt(input logic [BPC-1:0] v);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < BPC; i++) begin
            s = s + DW'(v[i]);
        end
        return s;
    endfunction

    // A lone valid requester always wins; ptr only breaks ties.
    assign grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        x_d         = x_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_dist_d  = res_dist_q;
        acc_sum     = acc_q + popcnt(x_q[BPC-1:0]);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = grant ? (req1_val1 ^ req1_val2) : (req0_val1 ^ req0_val2);
                    id_d    = grant;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                x_d   = x_q >> BPC;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    res_dist_d  = acc_sum;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    // The requester just served loses the next tie.
                    ptr_d       = ~res_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            x_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_dist_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_dist_q  <= res_dist_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_dist  = res_dist_q;

endmodule

// File: tb/tb_hamming_arb.sv
// Directed bench for hamming_arb at WIDTH=16, BPC=4 (N=4).
module tb_hamming_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_val1, req0_val2, req1_val1, req1_val2;
    logic        res_valid, res_ready, res_id;
    logic [4:0]  res_dist;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rdy_seen;

    hamming_arb #(.WIDTH(16), .BPC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_val1  (req0_val1),
        .req0_val2  (req0_val2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_val1  (req1_val1),
        .req1_val2  (req1_val2),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_dist   (res_dist)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until res_valid is seen (bounded); lat counts edges after the accept edge.
    task automatic wait_res(output int lat);
        lat = 0;
        rdy_seen = 1'b0;
        while (!res_valid && lat < 50) begin
            tick();
            lat++;
            if (req0_ready || req1_ready) rdy_seen = 1'b1;
        end
    endtask

    initial begin
        int lat;
        int n_res;
        int ids[6];
        int rise[6];
        int stable;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_val1 = '0; req0_val2 = '0; req1_val1 = '0; req1_val2 = '0;
        res_ready = 1'b0;
        tick(); tick();

        // Reset state; readys stay low during reset even with valid requests.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_dist", res_dist, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single request: 0011 ^ 1100 -> 4 bits.
        req0_valid = 1'b1; req0_val1 = 16'h0011; req0_val2 = 16'h1100;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        wait_res(lat);
        chk("single_latency", lat, 4);
        chk("single_dist", res_dist, 4);
        chk("single_id", res_id, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_consumed", res_valid, 0);
        chk("single_dist_kept", res_dist, 4);
        tick();

        // Both requesters valid as reset deasserts: req0 wins first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_val1 = 16'hFFFF; req0_val2 = 16'h0000;
        req1_valid = 1'b1; req1_val1 = 16'h1234; req1_val2 = 16'h1234;
        #1;
        chk("sim_ready0", req0_ready, 1);
        chk("sim_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        wait_res(lat);
        chk("sim_latency0", lat, 4);
        chk("sim_ready1_held_low", rdy_seen, 0);
        chk("sim_id0", res_id, 0);
        chk("sim_dist0", res_dist, 16);
        res_ready = 1'b1;
        #1;
        chk("sim_ready1_in_done", req1_ready, 0);
        tick();
        res_ready = 1'b0;
        #1;
        chk("sim_ready1_after_hs", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        wait_res(lat);
        chk("sim_latency1", lat, 4);
        chk("sim_id1", res_id, 1);
        chk("sim_dist1", res_dist, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();

        // Fairness: both valid, consumer always ready. req0 dist 4, req1 dist 8.
        req0_valid = 1'b1; req0_val1 = 16'h0000; req0_val2 = 16'h000F;
        req1_valid = 1'b1; req1_val1 = 16'h00FF; req1_val2 = 16'h0000;
        res_ready = 1'b1;
        n_res = 0;
        for (int i = 0; i < 100 && n_res < 6; i++) begin
            tick();
            if (res_valid) begin
                ids[n_res] = int'(res_id);
                rise[n_res] = cyc;
                chk("fair_dist", res_dist, res_id ? 8 : 4);
                n_res++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("fair_count", n_res, 6);
        for (int i = 0; i < n_res; i++) begin
            chk("fair_id", ids[i], i % 2);
            if (i > 0) chk("fair_spacing", rise[i] - rise[i-1], 6);
        end
        tick();
        res_ready = 1'b0;
        tick();

        // Backpressure: req1 alone, consumer stalls 10 cycles while req0 waits.
        req1_valid = 1'b1; req1_val1 = 16'hAAAA; req1_val2 = 16'h5555;
        #1;
        chk("bp_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_val1 = 16'h0001; req0_val2 = 16'h0000;
        wait_res(lat);
        chk("bp_latency", lat, 4);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid && res_dist == 5'd16 && res_id && !req0_ready && !req1_ready)
                stable++;
            tick();
        end
        chk("bp_stable_cycles", stable, 10);
        req0_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_consumed", res_valid, 0);
        tick(); tick(); tick();
        chk("bp_once", res_valid, 0);

        // Reset during CALC at cnt=2; result from re-accept must be fresh.
        req0_valid = 1'b1; req0_val1 = 16'hF0F0; req0_val2 = 16'h0F0F;
        #1;
        chk("mid_ready0", req0_ready, 1);
        tick();
        tick(); tick();
        chk("mid_no_result_yet", res_valid, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_id", res_id, 0);
        chk("mid_rst_dist", res_dist, 0);
        chk("mid_rst_ready0", req0_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_reaccept_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_res(lat);
        chk("mid_latency", lat, 4);
        chk("mid_dist", res_dist, 16);
        chk("mid_id", res_id, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();

        // Operand change after accept must not affect the result (00FF^00F0 -> 4).
        req0_valid = 1'b1; req0_val1 = 16'h00FF; req0_val2 = 16'h00F0;
        #1;
        chk("opchg_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0; req0_val1 = 16'hFFFF; req0_val2 = 16'h0000;
        wait_res(lat);
        chk("opchg_latency", lat, 4);
        chk("opchg_dist", res_dist, 4);
        chk("opchg_id", res_id, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("opchg_consumed", res_valid, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
